// File: rtl/fft_bfp_scaler_if.sv
// Stream bundle for the FFT block-floating-point normaliser: FFT source stream in,
// scaled fixed-point stream out, plus per-frame shift offset and drop counter.
interface fft_bfp_scaler_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int EXP_W = 6
);
    logic                    sink_valid;
    logic                    sink_ready;
    logic                    sink_sop;
    logic                    sink_eop;
    logic [1:0]              sink_error;
    logic signed [IN_W-1:0]  sink_real;
    logic signed [IN_W-1:0]  sink_imag;
    logic signed [EXP_W-1:0] sink_exp;
    logic signed [EXP_W-1:0] cfg_shift;
    logic                    source_valid;
    logic                    source_ready;
    logic                    source_sop;
    logic                    source_eop;
    logic [1:0]              source_error;
    logic signed [OUT_W-1:0] source_real;
    logic signed [OUT_W-1:0] source_imag;
    logic [7:0]              drop_cnt;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_error, sink_real, sink_imag,
               sink_exp, cfg_shift, source_ready,
        input  sink_ready, source_valid, source_sop, source_eop, source_error,
               source_real, source_imag, drop_cnt
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_error, sink_real, sink_imag,
               sink_exp, cfg_shift, source_ready,
        output sink_ready, source_valid, source_sop, source_eop, source_error,
               source_real, source_imag, drop_cnt
    );
endinterface

// File: rtl/fft_bfp_scaler.sv
// Block-floating-point output normaliser: applies frame exponent + offset as a rounded,
// saturated power-of-two shift and enforces frame length on the FFT output stream.
module fft_bfp_scaler #(
    parameter int IN_W      = 12,
    parameter int OUT_W     = 16,
    parameter int EXP_W     = 6,
    parameter int FRAME_LEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    fft_bfp_scaler_if.slave bus
);
    localparam int CW  = $clog2(FRAME_LEN);
    localparam int WW  = IN_W + OUT_W + 2;
    localparam int SHW = $clog2(WW) + 2;
    localparam logic [CW-1:0]         CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(32'd1);
    localparam logic [SHW-1:0]        SH_ONE   = SHW'(32'd1);
    localparam logic signed [WW-1:0]  WW_ONE   = WW'(32'sd1);
    localparam logic signed [WW-1:0]  SAT_MAX  = WW'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
    localparam logic signed [WW-1:0]  SAT_MIN  = WW'(-(32'sd1 <<< (OUT_W - 1)));

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FRAME = 1'b1} state_t;

    function automatic logic signed [SHW-1:0] clamp_shift(input logic signed [EXP_W-1:0] e,
                                                          input logic signed [EXP_W-1:0] c);
        int s_i;
        s_i = int'(e) + int'(c);
        if (s_i < -(IN_W + 1)) begin
            clamp_shift = SHW'(-(IN_W + 1));
        end else if (s_i > OUT_W) begin
            clamp_shift = SHW'(OUT_W);
        end else begin
            clamp_shift = SHW'(s_i);
        end
    endfunction

    // Right shifts add half an LSB first so the arithmetic shift rounds half up.
    function automatic logic signed [WW-1:0] scale(input logic signed [IN_W-1:0] x,
                                                   input logic signed [SHW-1:0] s);
        logic signed [WW-1:0] xe;
        logic signed [WW-1:0] rnd;
        logic [SHW-1:0]       n;
        xe = {{(WW - IN_W){x[IN_W-1]}}, x};
        if (s[SHW-1] == 1'b0) begin
            n     = s;
            rnd   = '0;
            scale = xe <<< n;
        end else begin
            n     = -s;
            rnd   = xe + (WW_ONE <<< (n - SH_ONE));
            scale = rnd >>> n;
        end
    endfunction

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [WW-1:0] v);
        if (v > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end else begin
            sat = v[OUT_W-1:0];
        end
    endfunction

    state_t                  state_r;
    logic [CW-1:0]           cnt_r;
    logic signed [SHW-1:0]   shift_r;
    logic [7:0]              drop_cnt_r;
    logic                    s1_valid_r, s1_sop_r, s1_eop_r;
    logic [1:0]              s1_err_r;
    logic signed [WW-1:0]    s1_re_r, s1_im_r;
    logic                    out_valid_r, out_sop_r, out_eop_r;
    logic [1:0]              out_err_r;
    logic signed [OUT_W-1:0] out_re_r, out_im_r;

    logic                    en_s, acc_s, fwd_s, f_sop_s, f_eop_s, f_err_s, latch_s;
    state_t                  state_nxt_s;
    logic [CW-1:0]           cnt_nxt_s;
    logic signed [SHW-1:0]   new_shift_s, cur_shift_s;

    assign en_s        = ~out_valid_r | bus.source_ready;
    assign acc_s       = bus.sink_valid & bus.sink_ready;
    assign new_shift_s = clamp_shift(bus.sink_exp, bus.cfg_shift);
    assign cur_shift_s = latch_s ? new_shift_s : shift_r;

    assign bus.sink_ready   = en_s & reset_n;
    assign bus.source_valid = out_valid_r;
    assign bus.source_sop   = out_sop_r;
    assign bus.source_eop   = out_eop_r;
    assign bus.source_error = out_err_r;
    assign bus.source_real  = out_re_r;
    assign bus.source_imag  = out_im_r;
    assign bus.drop_cnt     = drop_cnt_r;

    // Framing decision for the sample accepted this cycle.
    always_comb begin
        fwd_s       = 1'b0;
        f_sop_s     = 1'b0;
        f_eop_s     = 1'b0;
        f_err_s     = 1'b0;
        latch_s     = 1'b0;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (acc_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.sink_sop) begin
                        fwd_s       = 1'b1;
                        f_sop_s     = 1'b1;
                        latch_s     = 1'b1;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = ST_FRAME;
                    end else begin
                        fwd_s = 1'b0;
                    end
                end
                ST_FRAME: begin
                    fwd_s = 1'b1;
                    if (bus.sink_sop) begin
                        f_sop_s   = 1'b1;
                        f_err_s   = 1'b1;
                        latch_s   = 1'b1;
                        cnt_nxt_s = CNT_ONE;
                    end else if (cnt_r == CNT_LAST) begin
                        f_eop_s     = 1'b1;
                        f_err_s     = ~bus.sink_eop;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end else if (bus.sink_eop) begin
                        f_eop_s     = 1'b1;
                        f_err_s     = 1'b1;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame FSM, drop counter and the two pipeline stages, all advancing together on en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            shift_r     <= '0;
            drop_cnt_r  <= 8'd0;
            s1_valid_r  <= 1'b0;
            s1_sop_r    <= 1'b0;
            s1_eop_r    <= 1'b0;
            s1_err_r    <= 2'b00;
            s1_re_r     <= '0;
            s1_im_r     <= '0;
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_err_r   <= 2'b00;
            out_re_r    <= '0;
            out_im_r    <= '0;
        end else if (en_s) begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                shift_r <= new_shift_s;
            end
            if (acc_s && !fwd_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
            s1_valid_r <= acc_s & fwd_s;
            if (acc_s && fwd_s) begin
                s1_re_r  <= scale(bus.sink_real, cur_shift_s);
                s1_im_r  <= scale(bus.sink_imag, cur_shift_s);
                s1_sop_r <= f_sop_s;
                s1_eop_r <= f_eop_s;
                s1_err_r <= {bus.sink_error[1] | f_err_s, bus.sink_error[0]};
            end
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_re_r  <= sat(s1_re_r);
                out_im_r  <= sat(s1_im_r);
                out_sop_r <= s1_sop_r;
                out_eop_r <= s1_eop_r;
                out_err_r <= s1_err_r;
            end
        end
    end
endmodule

// File: tb/tb_fft_bfp_scaler.sv
// Self-checking bench for fft_bfp_scaler: directed test-plan frames plus randomized frames
// checked against an arithmetic reference model and expected-output queue.
module tb_fft_bfp_scaler;
    localparam int IN_W = 12, OUT_W = 16, EXP_W = 6, FRAME_LEN = 8;

    typedef struct {
        int         re;
        int         im;
        logic       sop;
        logic       eop;
        logic [1:0] err;
    } out_t;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode = 0;
    bit   tog = 1'b0;
    out_t exp_q[$];
    out_t obs_q[$];
    bit   m_in_frame = 1'b0;
    int   m_cnt = 0;
    int   m_shift = 0;
    int   m_drops = 0;

    fft_bfp_scaler_if #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W)) bus ();

    fft_bfp_scaler #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_W(EXP_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_shift(input int ex, input int cf);
        int s;
        s = ex + cf;
        if (s < -(IN_W + 1)) s = -(IN_W + 1);
        if (s > OUT_W) s = OUT_W;
        return s;
    endfunction

    // Multiply or divide by 2^|s| with floor(x/d + 1/2) rounding, then clip.
    function automatic int ref_scale(input int x, input int s);
        longint v, d, a, lim;
        if (s >= 0) begin
            v = longint'(x) * (64'sd1 <<< s);
        end else begin
            d = 64'sd1 <<< (-s);
            a = longint'(x) + d / 2;
            v = a / d;
            if ((a % d != 0) && (a < 0)) v = v - 1;
        end
        lim = 64'sd1 <<< (OUT_W - 1);
        if (v > lim - 1) v = lim - 1;
        if (v < -lim) v = -lim;
        return int'(v);
    endfunction

    task automatic model_accept(input bit sop, input bit eop, input logic [1:0] err,
                                input int re, input int im, input int ex, input int cf);
        out_t o;
        bit   fwd;
        fwd   = 1'b1;
        o.sop = 1'b0;
        o.eop = 1'b0;
        o.err = err;
        if (!m_in_frame) begin
            if (sop) begin
                m_shift = ref_shift(ex, cf); o.sop = 1'b1; m_in_frame = 1'b1; m_cnt = 1;
            end else begin
                fwd = 1'b0;
                if (m_drops < 255) m_drops++;
            end
        end else if (sop) begin
            m_shift = ref_shift(ex, cf); o.sop = 1'b1; o.err[1] = 1'b1; m_cnt = 1;
        end else if (m_cnt == FRAME_LEN - 1) begin
            o.eop = 1'b1; o.err[1] = err[1] | ~eop; m_in_frame = 1'b0;
        end else if (eop) begin
            o.eop = 1'b1; o.err[1] = 1'b1; m_in_frame = 1'b0;
        end else begin
            m_cnt++;
        end
        if (fwd) begin
            o.re = ref_scale(re, m_shift);
            o.im = ref_scale(im, m_shift);
            exp_q.push_back(o);
        end
    endtask

    task automatic send(input bit sop, input bit eop, input logic [1:0] err,
                        input int re, input int im, input int ex, input int cf);
        logic [31:0] rv, iv, ev, cv;
        rv = re; iv = im; ev = ex; cv = cf;
        @(negedge clk);
        bus.sink_valid = 1'b1;
        bus.sink_sop   = sop;
        bus.sink_eop   = eop;
        bus.sink_error = err;
        bus.sink_real  = rv[IN_W-1:0];
        bus.sink_imag  = iv[IN_W-1:0];
        bus.sink_exp   = ev[EXP_W-1:0];
        bus.cfg_shift  = cv[EXP_W-1:0];
        #1;
        for (int t = 0; t < 200 && !bus.sink_ready; t++) begin
            @(negedge clk);
            #1;
        end
        chk("sink_ready_wait", bus.sink_ready, 1);
        model_accept(sop, eop, err, re, im, ex, cf);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sink_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        #2;
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
            @(negedge clk);
            #2;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic send_frame(input int n, input int ex, input int cf, input int re0, input int im0,
                              input int re1, input int im1, input bit with_eop);
        int re, im;
        for (int i = 0; i < n; i++) begin
            re = (i == 0) ? re0 : (i == 1) ? re1 : int'($urandom_range(0, 4095)) - 2048;
            im = (i == 0) ? im0 : (i == 1) ? im1 : int'($urandom_range(0, 4095)) - 2048;
            send(i == 0, with_eop && (i == n - 1), 2'b00, re, im, ex, cf);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        reset_n        = 1'b0;
        bus.sink_valid = 1'b0;
        #1;
        chk("rst_source_valid", bus.source_valid, 0);
        chk("rst_sink_ready", bus.sink_ready, 0);
        chk("rst_source_sop", bus.source_sop, 0);
        chk("rst_source_eop", bus.source_eop, 0);
        chk("rst_source_error", bus.source_error, 0);
        chk("rst_source_real", bus.source_real, 0);
        chk("rst_source_imag", bus.source_imag, 0);
        chk("rst_drop_cnt", bus.drop_cnt, 0);
        exp_q.delete();
        obs_q.delete();
        m_in_frame = 1'b0;
        m_cnt      = 0;
        m_drops    = 0;
        @(negedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        chk("post_rst_sink_ready", bus.sink_ready, 1);
    endtask

    // Output monitor: drives source_ready per mode and scores every output transfer.
    initial begin
        out_t e, o;
        bus.source_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.source_ready = 1'b1;
                1:       begin tog = ~tog; bus.source_ready = tog; end
                default: bus.source_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (reset_n && bus.source_valid && bus.source_ready) begin
                chk("out_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_real", bus.source_real, e.re);
                    chk("out_imag", bus.source_imag, e.im);
                    chk("out_sop", bus.source_sop, e.sop);
                    chk("out_eop", bus.source_eop, e.eop);
                    chk("out_error", bus.source_error, e.err);
                end
                o.re  = bus.source_real;
                o.im  = bus.source_imag;
                o.sop = bus.source_sop;
                o.eop = bus.source_eop;
                o.err = bus.source_error;
                obs_q.push_back(o);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, ex, cf;
        bit sop;
        logic [1:0] err;
        reset_n = 1'b0;
        bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0; bus.sink_error = 2'b00;
        bus.sink_real = '0; bus.sink_imag = '0; bus.sink_exp = '0; bus.cfg_shift = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_source_valid", bus.source_valid, 0);
        chk("init_sink_ready", bus.sink_ready, 0);
        chk("init_drop_cnt", bus.drop_cnt, 0);
        chk("init_source_real", bus.source_real, 0);
        #2;
        reset_n = 1'b1;
        #1;
        chk("init_release_ready", bus.sink_ready, 1);

        // Shift-up cases: s=+2, +4, +5 (saturating).
        send_frame(8, 1, 1, 100, -100, 7, -1, 1'b1);
        drain();
        chk("s2_re", obs_q[0].re, 400);
        chk("s2_im", obs_q[0].im, -400);
        obs_q.delete();
        send_frame(8, 3, 1, -2048, 2047, 1, 0, 1'b1);
        drain();
        chk("s4_re", obs_q[0].re, -32768);
        chk("s4_im", obs_q[0].im, 32752);
        obs_q.delete();
        send(1'b1, 1'b0, 2'b00, 2047, -2048, 5, 0);
        idle();
        #1;
        chk("lat_cycle1_valid", bus.source_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_cycle2_valid", bus.source_valid, 1);
        for (int i = 1; i < 8; i++) send(1'b0, i == 7, 2'b00, i, -i, 5, 0);
        drain();
        chk("s5_sat_hi", obs_q[0].re, 32767);
        chk("s5_sat_lo", obs_q[0].im, -32768);
        obs_q.delete();

        // Rounding shifts: s=-2 and s=-20 clamped to -13.
        send_frame(8, -3, 1, 5, 6, -6, -5, 1'b1);
        drain();
        chk("sm2_5", obs_q[0].re, 1);
        chk("sm2_6", obs_q[0].im, 2);
        chk("sm2_m6", obs_q[1].re, -1);
        chk("sm2_m5", obs_q[1].im, -1);
        obs_q.delete();
        send_frame(8, -21, 1, 2047, -2048, 0, 0, 1'b1);
        drain();
        chk("clamp_re", obs_q[0].re, 0);
        chk("clamp_im", obs_q[0].im, 0);
        obs_q.delete();

        // Backpressure toggling every cycle.
        rdy_mode = 1;
        send_frame(8, 0, 0, 11, 12, 13, 14, 1'b1);
        drain();
        rdy_mode = 0;
        chk("tog_count", obs_q.size(), 8);
        chk("tog_sop_first", obs_q[0].sop, 1);
        chk("tog_eop_last", obs_q[7].eop, 1);
        chk("tog_err_last", obs_q[7].err, 0);
        obs_q.delete();

        // Drops before a frame, short frame, frame without eop.
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 2'b00, i, i, 0, 0);
        send_frame(8, 0, 0, 1, 2, 3, 4, 1'b1);
        drain();
        chk("drop_cnt_3", bus.drop_cnt, 3);
        chk("drop_frame_count", obs_q.size(), 8);
        obs_q.delete();
        send_frame(5, 0, 0, 1, 2, 3, 4, 1'b1);
        drain();
        chk("short_count", obs_q.size(), 5);
        chk("short_eop", obs_q[4].eop, 1);
        chk("short_err", obs_q[4].err, 2);
        obs_q.delete();
        send_frame(8, 0, 0, 1, 2, 3, 4, 1'b0);
        drain();
        chk("forced_eop", obs_q[7].eop, 1);
        chk("forced_err", obs_q[7].err, 2);
        obs_q.delete();

        // Upstream error on sample 3, re-sop on sample 4.
        for (int i = 0; i < 11; i++) begin
            send(i == 0 || i == 3, i == 10, (i == 2) ? 2'b01 : 2'b00, i, -i, 0, 1);
        end
        drain();
        chk("uerr_count", obs_q.size(), 11);
        chk("uerr_prev", obs_q[1].err, 0);
        chk("uerr_sample3", obs_q[2].err, 1);
        chk("resop_sop", obs_q[3].sop, 1);
        chk("resop_err", obs_q[3].err, 2);
        chk("resop_eop", obs_q[10].eop, 1);
        obs_q.delete();

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) send(i == 0, 1'b0, 2'b00, i, i, 0, 0);
        do_reset();
        send(1'b0, 1'b0, 2'b00, 5, 5, 0, 0);
        send(1'b0, 1'b0, 2'b00, 6, 6, 0, 0);
        send_frame(8, 0, 2, 9, -9, 10, -10, 1'b1);
        drain();
        chk("post_rst_drops", bus.drop_cnt, 2);
        chk("post_rst_count", obs_q.size(), 8);
        chk("post_rst_re0", obs_q[0].re, 36);
        obs_q.delete();

        // Randomized frames with random backpressure and mid-frame config changes.
        rdy_mode = 2;
        for (int f = 0; f < 25; f++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 11)) : FRAME_LEN;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) idle();
                ex  = int'($urandom_range(0, 42)) - 20;
                cf  = int'($urandom_range(0, 10)) - 5;
                err = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                sop = (i == 0) || ($urandom_range(0, 30) == 0);
                send(sop, i == len - 1, err, int'($urandom_range(0, 4095)) - 2048,
                     int'($urandom_range(0, 4095)) - 2048, ex, cf);
            end
        end
        drain();
        chk("rand_drop_cnt", bus.drop_cnt, m_drops);
        rdy_mode = 0;

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) send(1'b0, 1'b0, 2'b00, 0, 0, 0, 0);
        drain();
        chk("drop_sat", bus.drop_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_bfp_scaler.md
# fft_bfp_scaler

Parametrised block-floating-point output normaliser for the OFDM receiver FFT path. It accepts the FFT source stream (real/imag samples plus per-frame block exponent) with Avalon-ST style valid/ready/sop/eop/error, and applies the frame exponent plus a configurable offset as a signed power-of-two shift. Results are rounded and saturated to a generic output width. It also enforces frame length and reports framing faults, so downstream demapping sees fixed-point, correctly framed symbols.

## Interface
- IN_W, 12: signed width of sink_real/sink_imag
- OUT_W, 16: signed width of source_real/source_imag
- EXP_W, 6: signed width of sink_exp and cfg_shift
- FRAME_LEN, 64: samples per frame (power of two, 4..4096)
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- sink_valid  in  1  sample present
- sink_ready  out  1  block can accept sample this cycle
- sink_sop / sink_eop  in  1  first / last sample of frame
- sink_error  in  2  upstream error, propagated
- sink_real / sink_imag  in  IN_W  signed sample
- sink_exp  in  EXP_W  signed block exponent, sampled at sop
- cfg_shift  in  EXP_W  signed offset, sampled at sop
- source_valid / source_ready  out / in  1  output handshake
- source_sop / source_eop  out  1  output framing
- source_error  out  2  sink_error OR framing flags
- source_real / source_imag  out  OUT_W  scaled signed sample
- drop_cnt  out  8  saturating count of samples dropped outside a frame

## Operation
- Transfer = valid & ready on either side.
- Frame shift s = sink_exp + cfg_shift (EXP_W+1 bits), latched on accepted sop sample, held for the frame; clamped to [-(IN_W+1), OUT_W].
- s >= 0: y = x << s. s < 0, n = -s: y = (x + 2^(n-1)) >>> n (round half up, arithmetic). Computed at IN_W+OUT_W+2 bits, then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Real and imag independent.
- FSM IDLE / IN_FRAME, counter cnt (log2 FRAME_LEN bits).
- IDLE: accepted sample with sop -> forwarded, cnt=1, go IN_FRAME (if FRAME_LEN reached on that sample impossible since FRAME_LEN>=4). Accepted sample without sop -> dropped (not forwarded), drop_cnt+1 (saturates at 255).
- IN_FRAME, accepted sample:
  - sop again -> treated as new frame start (new s latched, cnt=1), forwarded with source_error[1]=1.
  - eop with cnt != FRAME_LEN-1 -> forwarded with eop and error[1]=1, go IDLE.
  - cnt == FRAME_LEN-1 -> forwarded with source_eop=1 forced; if sink_eop=0, error[1]=1; go IDLE.
  - otherwise forwarded, cnt+1; stray eop never forwarded mid-frame without termination.
- source_error[0] = sink_error[0]; source_error[1] = sink_error[1] | framing flag.

## Timing
- Two-stage pipeline (stage1: shift/round, stage2: saturate/register). Latency 2 cycles from sink transfer to source_valid when unstalled.
- Global advance en = ~source_valid | source_ready; sink_ready = en (combinational, no skid buffer). Stage registers and FSM update only when en.
- source_* data/framing stable while source_valid & ~source_ready.
- Full throughput: one sample per cycle with source_ready held high.
- Reset (async, any time incl. mid-frame): all outputs 0 (sink_ready 0 while reset_n=0, 1 first cycle after), FSM IDLE, cnt 0, drop_cnt 0, pipeline emptied; partial frame discarded, next frame must start with sop.
- cfg_shift/sink_exp changes mid-frame have no effect until next sop.

## Test plan
- IN_W=12, OUT_W=16, FRAME_LEN=8, s=+2: x=100 -> 400; s=+4, x=-2048 -> -32768; s=+5, x=2047 -> 32767, x=-2048 -> -32768 (saturate), 2 cycles latency.
- s=-2 (sink_exp=-3, cfg_shift=+1): x=5 -> 1, x=6 -> 2, x=-6 -> -1; s=-20 clamps to -13: x=2047 -> 0.
- 8-sample frame, source_ready toggled 1/0 every cycle: all 8 samples out in order, sop on 1st, eop on 8th, error 0, no duplication or loss.
- 3 samples without sop then valid frame: drop_cnt=3, frame passes; frame with eop on 5th -> eop and error[1] on 5th; frame of 8 without eop -> eop forced on 8th, error[1]=1.
- sink_error=2'b01 on sample 3 -> source_error=2'b01 on that output only; second sop at sample 4 -> new frame, error[1]=1.
- reset_n pulsed low mid-frame at sample 4 -> all outputs 0 immediately; samples after release without sop dropped; next sop frame correct.
